mul_seq_rv32: RTL

//   Multi-cycle shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU group. It is

---
 rtl/mul_seq_rv32.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mul_seq_rv32.sv
// Multi-cycle shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Computes on operand magnitudes and fixes the sign once after WIDTH ripple-add iterations.
module mul_seq_rv32 #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic               w_accept;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_result;

    logic               w_aSigned;
    logic               w_bSigned;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic               w_negIn;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH:0]     w_carry;
    logic [2*WIDTH-1:0] w_product;

    // Operand conditioning: the most negative value maps to its unsigned magnitude.
    assign w_aSigned = (op == 2'b01) || (op == 2'b10);
    assign w_bSigned = (op == 2'b01);
    assign w_magA    = (w_aSigned && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    assign w_magB    = (w_bSigned && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    assign w_negIn   = (w_aSigned & a[WIDTH-1]) ^ (w_bSigned & b[WIDTH-1]);

    assign w_addend   = r_mcand[0] ? r_mplier : '0;
    assign w_carry[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_fa
            assign w_sum[gi]     = r_acc[WIDTH+gi] ^ w_addend[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (r_acc[WIDTH+gi] & w_addend[gi])
                                 | (r_acc[WIDTH+gi] & w_carry[gi])
                                 | (w_addend[gi] & w_carry[gi]);
        end
    endgenerate

    assign w_product = r_neg ? (~r_acc + (2*WIDTH)'(1)) : r_acc;
    assign result    = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_stateNext = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_count == LAST_COUNT) begin
                    w_stateNext = S_FIX;
                end
            end
            S_FIX: begin
                busy        = 1'b1;
                w_stateNext = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept    = 1'b1;
                    w_stateNext = S_CALC;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Each CALC step folds the adder carry into the top bit as the accumulator shifts right.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op     <= op;
            r_mcand  <= w_magA;
            r_mplier <= w_magB;
            r_neg    <= w_negIn;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (r_state == S_CALC) begin
            r_acc   <= {w_carry[WIDTH], w_sum, r_acc[WIDTH-1:1]};
            r_mcand <= {1'b0, r_mcand[WIDTH-1:1]};
            r_count <= r_count + CW'(1);
        end else if (r_state == S_FIX) begin
            r_result <= (r_op == 2'b00) ? w_product[WIDTH-1:0]
                                        : w_product[2*WIDTH-1:WIDTH];
        end
    end

endmodule
